// File: rtl/filter_pkg.sv
// Shared constants and types for the 5x5 luma coefficient scheduler.
// Coefficients are signed Q2.8; the reset kernel is the identity (unity at the centre tap).
package filter_pkg;

    localparam int COEF_WIDTH = 10;
    localparam int NUM_TAPS   = 25;
    localparam int ADDR_WIDTH = 5;
    localparam int CENTER_TAP = 12;
    localparam int COEF_UNITY = 256;
    localparam int BANK_WIDTH = NUM_TAPS * COEF_WIDTH;

    typedef logic signed [COEF_WIDTH-1:0] coef_t;

    typedef enum logic {
        IDLE,
        ARMED
    } state_t;

    localparam logic [BANK_WIDTH-1:0] IDENTITY_BANK =
        BANK_WIDTH'(COEF_UNITY) << (CENTER_TAP * COEF_WIDTH);

    function automatic logic tap_in_range(logic [ADDR_WIDTH-1:0] addr);
        return addr <= ADDR_WIDTH'(NUM_TAPS - 1);
    endfunction

endpackage

// File: rtl/filter_coef_sched_if.sv
// Single-tap coefficient write port (valid/ready) into the scheduler's shadow bank.
interface filter_coef_sched_if
    import filter_pkg::*;
;
    logic                  i_cfg_valid;
    logic                  o_cfg_ready;
    logic [ADDR_WIDTH-1:0] i_cfg_addr;
    coef_t                 i_cfg_data;

    modport master (
        output i_cfg_valid,
        output i_cfg_addr,
        output i_cfg_data,
        input  o_cfg_ready
    );

    modport slave (
        input  i_cfg_valid,
        input  i_cfg_addr,
        input  i_cfg_data,
        output o_cfg_ready
    );

endinterface

// File: rtl/filter_coef_bank.sv
// Register bank of NUM_TAPS coefficients: single-tap write or whole-bank load,
// flattened parallel output, asynchronous reset to the identity kernel.
module filter_coef_bank
    import filter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  coef_t                 wr_data,
    input  logic                  load_en,
    input  logic [BANK_WIDTH-1:0] load_data,
    output logic [BANK_WIDTH-1:0] q
);

    // NOTE: this is a flop array, not a RAM macro, so it can and must be reset;
    // sequential state uses non-blocking assignments so every reader sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= IDENTITY_BANK;
        end else if (load_en) begin
            q <= load_data;
        end else if (wr_en && tap_in_range(wr_addr)) begin
            q[int'(wr_addr)*COEF_WIDTH +: COEF_WIDTH] <= wr_data;
        end
    end

endmodule

// File: rtl/filter_coef_sched.sv
// Frame-synchronous coefficient scheduler: writes go to a shadow bank, which is
// copied into the active bank on the first vsync rising edge after a commit.
module filter_coef_sched
    import filter_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    filter_coef_sched_if.slave        cfg,
    input  logic                      i_vs,
    input  logic                      i_cfg_bypass,
    input  logic                      i_commit,
    output logic                      o_pending,
    output logic                      o_commit_done,
    output logic                      o_err,
    input  logic [ADDR_WIDTH-1:0]     i_rd_addr,
    output coef_t                     o_rd_data,
    output logic [BANK_WIDTH-1:0]     o_coef,
    output logic                      o_bypass
);

    state_t                state;
    logic                  vs_d;
    logic                  shadow_bypass;
    logic [BANK_WIDTH-1:0] shadow_q;
    logic                  accept;
    logic                  addr_ok;
    logic                  vs_rise;
    logic                  do_swap;
    coef_t                 rd_word;

    assign accept  = cfg.i_cfg_valid & cfg.o_cfg_ready;
    assign addr_ok = tap_in_range(cfg.i_cfg_addr);
    assign vs_rise = i_vs & ~vs_d;
    assign do_swap = (state == ARMED) & vs_rise;

    filter_coef_bank u_shadow (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (accept & addr_ok),
        .wr_addr   (cfg.i_cfg_addr),
        .wr_data   (cfg.i_cfg_data),
        .load_en   (1'b0),
        .load_data ('0),
        .q         (shadow_q)
    );

    filter_coef_bank u_active (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (1'b0),
        .wr_addr   ('0),
        .wr_data   ('0),
        .load_en   (do_swap),
        .load_data (shadow_q),
        .q         (o_coef)
    );

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        rd_word = '0;
        if (tap_in_range(i_rd_addr)) begin
            rd_word = o_coef[int'(i_rd_addr)*COEF_WIDTH +: COEF_WIDTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            cfg.o_cfg_ready <= 1'b1;
            o_pending       <= 1'b0;
            o_commit_done   <= 1'b0;
            o_err           <= 1'b0;
            o_rd_data       <= '0;
            o_bypass        <= 1'b1;
            shadow_bypass   <= 1'b1;
            vs_d            <= 1'b0;
        end else begin
            vs_d          <= i_vs;
            o_commit_done <= 1'b0;
            o_err         <= accept & ~addr_ok;
            o_rd_data     <= rd_word;
            case (state)
                IDLE: begin
                    if (i_commit) begin
                        shadow_bypass   <= i_cfg_bypass;
                        state           <= ARMED;
                        cfg.o_cfg_ready <= 1'b0;
                        o_pending       <= 1'b1;
                    end
                end
                ARMED: begin
                    // Commit pulses here are ignored; only a fresh vsync edge releases the bank.
                    if (vs_rise) begin
                        o_bypass        <= shadow_bypass;
                        o_commit_done   <= 1'b1;
                        state           <= IDLE;
                        cfg.o_cfg_ready <= 1'b1;
                        o_pending       <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_filter_coef_sched.sv
// Self-checking bench for filter_coef_sched: directed test-plan steps followed by
// random traffic, all compared against a per-cycle array model of the scheduler.
module tb_filter_coef_sched;
    import filter_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  vs;
    logic                  cfg_bypass;
    logic                  commit;
    logic                  pending;
    logic                  commit_done;
    logic                  err;
    logic [ADDR_WIDTH-1:0] rd_addr;
    coef_t                 rd_data;
    logic [BANK_WIDTH-1:0] coef;
    logic                  bypass;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    filter_coef_sched_if cfg_if ();

    filter_coef_sched dut (
        .clk           (clk),
        .rst           (rst),
        .cfg           (cfg_if),
        .i_vs          (vs),
        .i_cfg_bypass  (cfg_bypass),
        .i_commit      (commit),
        .o_pending     (pending),
        .o_commit_done (commit_done),
        .o_err         (err),
        .i_rd_addr     (rd_addr),
        .o_rd_data     (rd_data),
        .o_coef        (coef),
        .o_bypass      (bypass)
    );

    // Reference model: two coefficient arrays plus the armed flag.
    coef_t shadow_m [NUM_TAPS];
    coef_t active_m [NUM_TAPS];
    bit    sh_byp_m, byp_m, armed_m, vs_prev_m, done_m, err_m;
    coef_t rd_m;

    task automatic model_reset();
        for (int k = 0; k < NUM_TAPS; k++) begin
            shadow_m[k] = (k == CENTER_TAP) ? coef_t'(COEF_UNITY) : coef_t'(0);
            active_m[k] = shadow_m[k];
        end
        sh_byp_m = 1'b1; byp_m = 1'b1; armed_m = 1'b0;
        vs_prev_m = 1'b0; done_m = 1'b0; err_m = 1'b0; rd_m = '0;
    endtask

    task automatic model_edge();
        bit accept;
        accept = cfg_if.i_cfg_valid && !armed_m;
        done_m = 1'b0;
        err_m  = 1'b0;
        rd_m   = (int'(rd_addr) < NUM_TAPS) ? active_m[int'(rd_addr)] : coef_t'(0);
        if (accept) begin
            if (int'(cfg_if.i_cfg_addr) < NUM_TAPS) shadow_m[int'(cfg_if.i_cfg_addr)] = cfg_if.i_cfg_data;
            else err_m = 1'b1;
        end
        if (!armed_m) begin
            if (commit) begin
                sh_byp_m = cfg_bypass;
                armed_m  = 1'b1;
            end
        end else if (vs && !vs_prev_m) begin
            active_m = shadow_m;
            byp_m    = sh_byp_m;
            done_m   = 1'b1;
            armed_m  = 1'b0;
        end
        vs_prev_m = vs;
    endtask

    task automatic check(string tag, logic [BANK_WIDTH-1:0] obs, logic [BANK_WIDTH-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        logic [BANK_WIDTH-1:0] exp_bank;
        exp_bank = '0;
        for (int k = 0; k < NUM_TAPS; k++) exp_bank[k*COEF_WIDTH +: COEF_WIDTH] = active_m[k];
        check({tag, ".coef"},    coef, exp_bank);
        check({tag, ".bypass"},  BANK_WIDTH'(bypass),             BANK_WIDTH'(byp_m));
        check({tag, ".pending"}, BANK_WIDTH'(pending),            BANK_WIDTH'(armed_m));
        check({tag, ".ready"},   BANK_WIDTH'(cfg_if.o_cfg_ready), BANK_WIDTH'(!armed_m));
        check({tag, ".done"},    BANK_WIDTH'(commit_done),        BANK_WIDTH'(done_m));
        check({tag, ".err"},     BANK_WIDTH'(err),                BANK_WIDTH'(err_m));
        check({tag, ".rd"},      BANK_WIDTH'($unsigned(rd_data)), BANK_WIDTH'($unsigned(rd_m)));
    endtask

    // One clock: model advances on the edge, outputs are compared on the falling edge.
    task automatic cycle(string tag);
        @(posedge clk);
        if (!rst) model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic drive_idle();
        cfg_if.i_cfg_valid = 1'b0;
        cfg_if.i_cfg_addr  = '0;
        cfg_if.i_cfg_data  = '0;
        commit             = 1'b0;
    endtask

    task automatic write(logic [ADDR_WIDTH-1:0] a, coef_t d);
        cfg_if.i_cfg_valid = 1'b1;
        cfg_if.i_cfg_addr  = a;
        cfg_if.i_cfg_data  = d;
    endtask

    initial begin
        // Reset and quiet period
        rst = 1'b1; vs = 1'b0; cfg_bypass = 1'b0; rd_addr = '0;
        drive_idle();
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        check("reset.tap12", BANK_WIDTH'(coef[CENTER_TAP*COEF_WIDTH +: COEF_WIDTH]), BANK_WIDTH'(COEF_UNITY));
        rst = 1'b0;
        rd_addr = ADDR_WIDTH'(CENTER_TAP);
        repeat (3) cycle("quiet");

        // Write tap0=-3, tap24=100, commit with bypass=0, then vsync
        write(5'd0, coef_t'(-3));  cycle("wr0");
        write(5'd24, coef_t'(100)); cycle("wr24");
        drive_idle(); commit = 1'b1; cfg_bypass = 1'b0; cycle("commit1");
        commit = 1'b0; repeat (3) cycle("armed1");
        vs = 1'b1; cycle("swap1");
        check("swap1.tap0", BANK_WIDTH'(coef[0 +: COEF_WIDTH]), BANK_WIDTH'(10'h3FD));
        check("swap1.tap24", BANK_WIDTH'(coef[24*COEF_WIDTH +: COEF_WIDTH]), BANK_WIDTH'(100));
        check("swap1.bypass", BANK_WIDTH'(bypass), BANK_WIDTH'(0));
        cycle("post_swap1");
        check("swap1.single_pulse", BANK_WIDTH'(commit_done), BANK_WIDTH'(0));
        vs = 1'b0; cycle("vs_low1");

        // Commit while vsync is already high: swap only after a fresh rise
        write(5'd3, coef_t'(55)); cycle("wr3");
        drive_idle(); vs = 1'b1; cycle("vs_high");
        commit = 1'b1; cfg_bypass = 1'b1; cycle("commit2");
        commit = 1'b0; repeat (3) cycle("held_high");
        vs = 1'b0; repeat (2) cycle("vs_fall");
        vs = 1'b1; cycle("swap2");
        repeat (2) cycle("post_swap2");
        vs = 1'b0; cycle("vs_low2");

        // Out-of-range write: error pulse, banks untouched after the next commit
        write(5'd25, coef_t'(10'h155)); cycle("wr25");
        drive_idle(); cycle("err_clear");
        commit = 1'b1; cycle("commit3");
        commit = 1'b0; vs = 1'b1; cycle("swap3");
        vs = 1'b0;
        for (int a = 0; a < 32; a++) begin
            rd_addr = ADDR_WIDTH'(a);
            cycle("readback");
        end
        rd_addr = 5'd5;
        cycle("readback_last");

        // Write and commit in the same cycle; a write during ARMED waits for ready
        write(5'd5, coef_t'(7)); commit = 1'b1; cycle("wr5_commit");
        commit = 1'b0; write(5'd6, coef_t'(9));
        repeat (2) cycle("armed_stall");
        vs = 1'b1; cycle("swap4");
        cycle("stall_accept");
        drive_idle(); vs = 1'b0; cycle("rd5");
        check("rd5.value", BANK_WIDTH'($unsigned(rd_data)), BANK_WIDTH'(7));

        // Reset while armed: commit lost, banks back to identity
        write(5'd1, coef_t'(-100)); cycle("wr1");
        drive_idle(); commit = 1'b1; cycle("commit5");
        commit = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("rst_armed");
        @(negedge clk);
        rst = 1'b0;
        cycle("after_rst");
        vs = 1'b1; cycle("vs_after_rst");
        check("rst.no_done", BANK_WIDTH'(commit_done), BANK_WIDTH'(0));
        vs = 1'b0; cycle("vs_low3");

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            cfg_if.i_cfg_valid = 1'($urandom_range(0, 1));
            cfg_if.i_cfg_addr  = ADDR_WIDTH'($urandom_range(0, 31));
            cfg_if.i_cfg_data  = coef_t'($urandom);
            commit             = ($urandom_range(0, 7) == 0);
            cfg_bypass         = 1'($urandom_range(0, 1));
            rd_addr            = ADDR_WIDTH'($urandom_range(0, 31));
            if ($urandom_range(0, 5) == 0) vs = ~vs;
            cycle("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/filter_coef_sched.md
# filter_coef_sched

Frame-synchronous coefficient scheduler for the 5x5 luma convolution path. Accepts single-tap coefficient writes over a valid/ready port into a shadow bank, then swaps the shadow bank into the active bank on the first vsync rising edge after a commit request. Drives the 25 coefficient inputs and the bypass input of the filter top, so coefficients never change mid-frame.

## Interface
- COEF_WIDTH, 10, signed coefficient width, Q2.8 (unity = 256)
- NUM_TAPS, 25, taps in the 5x5 kernel; tap index = row*5 + col
- ADDR_WIDTH, 5, tap address width
- clk  in  1  sole clock
- rst  in  1  reset, asynchronous, active-high
- i_vs  in  1  vsync from the video input, same as the filter top's i_vs
- i_cfg_valid  in  1  write request
- o_cfg_ready  out  1  write accepted when valid & ready
- i_cfg_addr  in  ADDR_WIDTH  tap index 0..24
- i_cfg_data  in  COEF_WIDTH  coefficient value
- i_cfg_bypass  in  1  bypass value staged into the shadow bank on commit request
- i_commit  in  1  single-cycle pulse that arms the swap
- o_pending  out  1  high while armed, waiting for vsync
- o_commit_done  out  1  one-cycle pulse when the swap occurs
- o_err  out  1  one-cycle pulse when an accepted write has addr >= NUM_TAPS
- i_rd_addr  in  ADDR_WIDTH  readback address into the active bank
- o_rd_data  out  COEF_WIDTH  active-bank readback, registered
- o_coef  out  NUM_TAPS*COEF_WIDTH  active bank, flattened; tap k at [k*COEF_WIDTH +: COEF_WIDTH]
- o_bypass  out  1  active bypass

## Operation
- FSM states: IDLE and ARMED.
  - IDLE: o_cfg_ready=1. An accepted write updates shadow[addr].
  - IDLE, i_commit=1: latch i_cfg_bypass into shadow_bypass, then go to ARMED.
  - ARMED: o_cfg_ready=0, so the shadow bank is frozen. o_pending=1.
  - ARMED, vs_rise: active bank <= shadow bank, o_bypass <= shadow_bypass, pulse o_commit_done, go to IDLE.
- vs_rise = i_vs & ~vs_d, where vs_d is i_vs registered.
- Write and i_commit in the same IDLE cycle: the write lands in the shadow bank first, and that value is included in the commit.
- i_commit while ARMED is ignored, with no error.
- vs_rise while in IDLE has no effect.
- Address out of range (>= 25): the write is still handshaken (ready=1), data is discarded, and o_err pulses for 1 cycle.
- The shadow bank persists after a swap. Partial updates followed by a commit reuse the unchanged taps.
- Readback: o_rd_data <= active[i_rd_addr]. Addresses >= 25 read 0.
- No arithmetic is performed. Coefficients pass through bit-exact.

## Timing
- Reset values:
  - all taps 0 except tap 12 = 256 (identity kernel), in both shadow and active banks
  - o_bypass=1, shadow_bypass=1
  - state IDLE, o_cfg_ready=1, o_pending=0, o_commit_done=0, o_err=0, o_rd_data=0, vs_d=0
- Write: accepted at edge N; the shadow bank reflects it from cycle N+1.
- Commit: i_commit sampled at edge N, so o_pending=1 and o_cfg_ready=0 from N+1.
- Swap: with i_i_vs first sampled high at edge M while ARMED, o_coef, o_bypass and o_commit_done update at M and are visible in cycle M+1. o_pending=0 and o_cfg_ready=1 from M+1.
- If i_vs is already high when arming, no swap happens until i_vs falls and rises again.
- Readback latency is 1 cycle.
- rst mid-ARMED: returns to IDLE with both banks at identity. The pending commit is lost and no o_commit_done is issued.
- All outputs are registered. There is no combinational path from inputs to o_coef.

## Structure
- Package filter_pkg contains:
  - COEF_WIDTH, NUM_TAPS, CENTER_TAP=12, COEF_UNITY=256
  - the state enum {IDLE, ARMED}
- Sub-module filter_coef_bank is instantiated twice (shadow and active). It is a register array with an async reset to identity, one write port (or a full-bank parallel load), and a flattened parallel output.

## Test plan
- Reset, then no activity → o_coef tap12=256, all other taps 0, o_bypass=1, o_pending=0.
- Write tap0=-3 (0x3FD) and tap24=100, commit with bypass=0, then raise i_vs → o_coef unchanged before the edge. One cycle after the vs edge, tap0=0x3FD, tap24=100, o_bypass=0, and o_commit_done is a single pulse.
- Commit while i_vs is held high → no swap. After i_vs falls and rises again, the swap occurs exactly once.
- Write to addr 25 with data 0x155 → o_err pulses once, and readback of every tap is unchanged after the next commit.
- Write tap5=7 in the same cycle as i_commit → that tap reads back 7 after the vsync swap. A valid write during ARMED sees ready=0 until the cycle after the swap.
- Assert rst while ARMED, then apply a vsync edge → no o_commit_done, and banks stay at identity.
